// File: rtl/ms_hls_deadlock_report_unit.sv
// rtl/ms_hls_deadlock_report_unit.sv - central deadlock origin select, loop trace and report latch
//
// Sits downstream of the per-process deadlock detect units of one dataflow region.
// It picks one origin process and broadcasts dl_detect_out so the units enter
// token-controlled mode. It then pulses the origin, follows the token until it returns
// or times out, and holds a single report until the consumer acknowledges it.
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous active-low reset
//   proc_dl_vec     per-unit dl_detect_out
//   proc_token_vec  per-unit OR of token_out_vec
//   report_ack      consumer accepts the report while report_vld=1
//   dl_detect_out   global deadlock flag to every unit's dl_detect_in
//   origin_vec      one-hot origin pulse, ORIGIN state only
//   token_clear     broadcast token clear on the TRACE exit cycle
//   report_vld      report valid, held until acked
//   report_proc_id  origin process index
//   report_chain    processes visited by the token, origin included
//   report_closed   1 = loop closed, 0 = timeout
//   report_cycles   TRACE count at close/timeout
module ms_hls_deadlock_report_unit #(
    parameter int PROC_NUM      = 4,
    parameter int PROC_ID_W     = 2,
    parameter int TOKEN_TIMEOUT = 16,
    parameter int CNT_W         = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PROC_NUM-1:0]  proc_dl_vec,
    input  logic [PROC_NUM-1:0]  proc_token_vec,
    input  logic                 report_ack,
    output logic                 dl_detect_out,
    output logic [PROC_NUM-1:0]  origin_vec,
    output logic                 token_clear,
    output logic                 report_vld,
    output logic [PROC_ID_W-1:0] report_proc_id,
    output logic [PROC_NUM-1:0]  report_chain,
    output logic                 report_closed,
    output logic [CNT_W-1:0]     report_cycles
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ORIGIN = 3'd1,
        TRACE  = 3'd2,
        REPORT = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t               state;
    logic [PROC_ID_W-1:0] origin_id;
    logic [PROC_NUM-1:0]  chain;
    logic [CNT_W-1:0]     cnt;

    logic [PROC_ID_W-1:0] low_id;
    logic                 close_hit;
    logic                 timeout_hit;

    // Lowest set bit wins: scan downward so the last assignment is the lowest index.
    always_comb begin
        low_id = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (proc_dl_vec[i]) begin
                low_id = PROC_ID_W'(i);
            end
        end
    end

    // The origin unit re-asserting its detect means the token came back around.
    assign close_hit   = (state == TRACE) && proc_dl_vec[origin_id];
    assign timeout_hit = (state == TRACE) && (cnt == CNT_W'(TOKEN_TIMEOUT - 1));

    assign origin_vec  = (state == ORIGIN) ? (PROC_NUM'(1) << origin_id) : '0;
    assign token_clear = close_hit || timeout_hit;
    assign report_vld  = (state == REPORT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            origin_id      <= '0;
            chain          <= '0;
            cnt            <= '0;
            dl_detect_out  <= 1'b0;
            report_proc_id <= '0;
            report_chain   <= '0;
            report_closed  <= 1'b0;
            report_cycles  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|proc_dl_vec) begin
                        origin_id     <= low_id;
                        dl_detect_out <= 1'b1;
                        state         <= ORIGIN;
                    end
                end
                ORIGIN: begin
                    chain <= PROC_NUM'(1) << origin_id;
                    cnt   <= '0;
                    state <= TRACE;
                end
                TRACE: begin
                    chain <= chain | proc_token_vec;
                    if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                    // Close takes priority over timeout when both land on the same cycle.
                    if (close_hit || timeout_hit) begin
                        report_proc_id <= origin_id;
                        report_chain   <= chain | proc_token_vec;
                        report_closed  <= close_hit;
                        report_cycles  <= cnt;
                        state          <= REPORT;
                    end
                end
                REPORT: begin
                    if (report_ack) begin
                        state <= HALT;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_hls_deadlock_report_unit.sv
// tb/tb_ms_hls_deadlock_report_unit.sv - directed bench for ms_hls_deadlock_report_unit
module tb_ms_hls_deadlock_report_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] proc_dl_vec = '0;
    logic [3:0] proc_token_vec = '0;
    logic       report_ack = 1'b0;
    logic       dl_detect_out;
    logic [3:0] origin_vec;
    logic       token_clear;
    logic       report_vld;
    logic [1:0] report_proc_id;
    logic [3:0] report_chain;
    logic       report_closed;
    logic [4:0] report_cycles;

    int vectors = 0;
    int miscompares = 0;

    ms_hls_deadlock_report_unit #(
        .PROC_NUM(4), .PROC_ID_W(2), .TOKEN_TIMEOUT(16), .CNT_W(5)
    ) dut (
        .clock(clock), .reset(reset),
        .proc_dl_vec(proc_dl_vec), .proc_token_vec(proc_token_vec),
        .report_ack(report_ack), .dl_detect_out(dl_detect_out),
        .origin_vec(origin_vec), .token_clear(token_clear),
        .report_vld(report_vld), .report_proc_id(report_proc_id),
        .report_chain(report_chain), .report_closed(report_closed),
        .report_cycles(report_cycles)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        proc_dl_vec = '0;
        proc_token_vec = '0;
        report_ack = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            proc_dl_vec = 4'($urandom);
            proc_token_vec = 4'($urandom);
            report_ack = 1'($urandom);
            @(negedge clock);
            vectors++;
            if ({dl_detect_out, origin_vec, token_clear, report_vld, report_proc_id, report_chain, report_closed, report_cycles} !== 19'd0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d: got dl=%b org=%b tc=%b vld=%b id=%0d ch=%b cl=%b cy=%0d, want all 0",
                         i, dl_detect_out, origin_vec, token_clear, report_vld, report_proc_id, report_chain, report_closed, report_cycles);
            end
        end
        proc_dl_vec = '0;
        proc_token_vec = '0;
        report_ack = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        vectors++;
        if ({dl_detect_out, origin_vec, token_clear, report_vld} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got dl=%b org=%b tc=%b vld=%b, want 0", dl_detect_out, origin_vec, token_clear, report_vld);
        end
    endtask

    task automatic test_loop_close();
        do_reset();
        proc_dl_vec = 4'b0100;
        #1;
        vectors++;
        if (dl_detect_out !== 1'b0) begin miscompares++; $display("FAIL close_detect_cycle_dl: got %b want 0", dl_detect_out); end
        cyc();
        proc_dl_vec = 4'b0000;
        #1;
        vectors++;
        if (dl_detect_out !== 1'b1) begin miscompares++; $display("FAIL close_origin_dl: got %b want 1", dl_detect_out); end
        vectors++;
        if (origin_vec !== 4'b0100) begin miscompares++; $display("FAIL close_origin_vec: got %b want 0100", origin_vec); end
        cyc();
        proc_token_vec = 4'b0100;
        #1;
        vectors++;
        if (origin_vec !== 4'b0000 || token_clear !== 1'b0) begin
            miscompares++; $display("FAIL close_trace0: got org=%b tc=%b want 0000/0", origin_vec, token_clear);
        end
        cyc();
        proc_token_vec = 4'b1000;
        cyc();
        proc_token_vec = 4'b0001;
        cyc();
        proc_token_vec = 4'b0000;
        proc_dl_vec = 4'b0100;
        #1;
        vectors++;
        if (token_clear !== 1'b1) begin miscompares++; $display("FAIL close_token_clear: got %b want 1", token_clear); end
        cyc();
        proc_dl_vec = 4'b0000;
        #1;
        vectors++;
        if (report_vld !== 1'b1 || report_proc_id !== 2'd2 || report_chain !== 4'b1101 || report_closed !== 1'b1 || report_cycles !== 5'd3 || token_clear !== 1'b0) begin
            miscompares++;
            $display("FAIL close_report: got vld=%b id=%0d ch=%b cl=%b cy=%0d tc=%b want 1/2/1101/1/3/0",
                     report_vld, report_proc_id, report_chain, report_closed, report_cycles, token_clear);
        end
        report_ack = 1'b1;
        cyc();
        report_ack = 1'b0;
        #1;
        vectors++;
        if (report_vld !== 1'b0 || dl_detect_out !== 1'b1 || report_chain !== 4'b1101 || report_cycles !== 5'd3) begin
            miscompares++;
            $display("FAIL close_halt: got vld=%b dl=%b ch=%b cy=%0d want 0/1/1101/3", report_vld, dl_detect_out, report_chain, report_cycles);
        end
    endtask

    task automatic test_priority();
        do_reset();
        proc_dl_vec = 4'b1010;
        cyc();
        proc_dl_vec = 4'b0000;
        #1;
        vectors++;
        if (origin_vec !== 4'b0010) begin miscompares++; $display("FAIL prio_origin_vec: got %b want 0010", origin_vec); end
        cyc();
        proc_dl_vec = 4'b0010;
        #1;
        vectors++;
        if (token_clear !== 1'b1) begin miscompares++; $display("FAIL prio_token_clear: got %b want 1", token_clear); end
        cyc();
        proc_dl_vec = 4'b0000;
        #1;
        vectors++;
        if (report_vld !== 1'b1 || report_proc_id !== 2'd1 || report_chain !== 4'b0010 || report_closed !== 1'b1 || report_cycles !== 5'd0) begin
            miscompares++;
            $display("FAIL prio_report: got vld=%b id=%0d ch=%b cl=%b cy=%0d want 1/1/0010/1/0",
                     report_vld, report_proc_id, report_chain, report_closed, report_cycles);
        end
    endtask

    task automatic test_timeout_backpressure();
        int bad_tc;
        int bad_stable;
        do_reset();
        proc_dl_vec = 4'b0001;
        cyc();
        proc_dl_vec = 4'b0000;
        cyc();
        bad_tc = 0;
        for (int k = 0; k < 16; k++) begin
            proc_dl_vec = 4'b1110;
            proc_token_vec = (k == 3) ? 4'b0010 : (k == 7) ? 4'b0100 : 4'b0000;
            #1;
            if (token_clear !== (k == 15)) begin
                bad_tc++;
                $display("FAIL timeout_token_clear k=%0d: got %b want %b", k, token_clear, (k == 15));
            end
            cyc();
        end
        vectors++;
        if (bad_tc != 0) miscompares++;
        proc_token_vec = 4'b0000;
        #1;
        vectors++;
        if (report_vld !== 1'b1 || report_proc_id !== 2'd0 || report_chain !== 4'b0111 || report_closed !== 1'b0 || report_cycles !== 5'd15) begin
            miscompares++;
            $display("FAIL timeout_report: got vld=%b id=%0d ch=%b cl=%b cy=%0d want 1/0/0111/0/15",
                     report_vld, report_proc_id, report_chain, report_closed, report_cycles);
        end
        bad_stable = 0;
        for (int k = 0; k < 10; k++) begin
            report_ack = 1'b0;
            proc_dl_vec = 4'($urandom);
            cyc();
            if (report_vld !== 1'b1 || report_proc_id !== 2'd0 || report_chain !== 4'b0111 || report_closed !== 1'b0 || report_cycles !== 5'd15 || origin_vec !== 4'b0000) begin
                bad_stable++;
                $display("FAIL bp_stable k=%0d: got vld=%b ch=%b cl=%b cy=%0d org=%b", k, report_vld, report_chain, report_closed, report_cycles, origin_vec);
            end
        end
        vectors++;
        if (bad_stable != 0) miscompares++;
        report_ack = 1'b1;
        #1;
        vectors++;
        if (report_vld !== 1'b1) begin miscompares++; $display("FAIL bp_ack_cycle_vld: got %b want 1", report_vld); end
        cyc();
        report_ack = 1'b0;
        #1;
        vectors++;
        if (report_vld !== 1'b0) begin miscompares++; $display("FAIL bp_vld_drop: got %b want 0", report_vld); end
        bad_stable = 0;
        for (int k = 0; k < 6; k++) begin
            proc_dl_vec = 4'b1111;
            proc_token_vec = 4'b1111;
            report_ack = 1'b1;
            cyc();
            if (origin_vec !== 4'b0000 || token_clear !== 1'b0 || report_vld !== 1'b0 || dl_detect_out !== 1'b1 || report_cycles !== 5'd15) begin
                bad_stable++;
                $display("FAIL halt_quiet k=%0d: got org=%b tc=%b vld=%b dl=%b cy=%0d", k, origin_vec, token_clear, report_vld, dl_detect_out, report_cycles);
            end
        end
        vectors++;
        if (bad_stable != 0) miscompares++;
        proc_dl_vec = '0;
        proc_token_vec = '0;
        report_ack = 1'b0;
    endtask

    task automatic test_reset_mid_trace();
        do_reset();
        proc_dl_vec = 4'b1000;
        cyc();
        proc_dl_vec = 4'b0000;
        cyc();
        proc_token_vec = 4'b0100;
        cyc();
        proc_token_vec = 4'b0001;
        cyc();
        reset = 1'b0;
        #1;
        vectors++;
        if ({dl_detect_out, origin_vec, token_clear, report_vld, report_proc_id, report_chain, report_closed, report_cycles} !== 19'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got dl=%b org=%b tc=%b vld=%b ch=%b, want all 0", dl_detect_out, origin_vec, token_clear, report_vld, report_chain);
        end
        proc_token_vec = 4'b0000;
        cyc();
        reset = 1'b1;
        cyc();
        proc_dl_vec = 4'b0100;
        cyc();
        proc_dl_vec = 4'b0000;
        #1;
        vectors++;
        if (origin_vec !== 4'b0100) begin miscompares++; $display("FAIL midreset_origin: got %b want 0100", origin_vec); end
        cyc();
        proc_token_vec = 4'b0010;
        cyc();
        proc_token_vec = 4'b0000;
        proc_dl_vec = 4'b0100;
        cyc();
        proc_dl_vec = 4'b0000;
        #1;
        vectors++;
        if (report_vld !== 1'b1 || report_proc_id !== 2'd2 || report_chain !== 4'b0110 || report_closed !== 1'b1 || report_cycles !== 5'd1) begin
            miscompares++;
            $display("FAIL midreset_report: got vld=%b id=%0d ch=%b cl=%b cy=%0d want 1/2/0110/1/1",
                     report_vld, report_proc_id, report_chain, report_closed, report_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_loop_close();
        test_priority();
        test_timeout_backpressure();
        test_reset_mid_trace();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
